// File: rtl/pc_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | pc_pkg : shared widths and enums for the fetch stage (pc_fetch_ctrl)        |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
package pc_pkg;

  localparam int unsigned c_PC_W  = 10;
  localparam int unsigned c_OFF_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  typedef enum logic [2:0] {
    NPC_HOLD = 3'd0,
    NPC_INC  = 3'd1,
    NPC_JUMP = 3'd2,
    NPC_REL  = 3'd3,
    NPC_LOAD = 3'd4
  } npc_sel_t;

endpackage
`default_nettype wire

// File: rtl/pc_fetch_ctrl_next_calc.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | pc_next_calc : combinational next-PC mux with carry/borrow wrap detection   |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module pc_next_calc
  import pc_pkg::*;
#(
  parameter int unsigned     PC_W       = c_PC_W,
  parameter int unsigned     OFF_W      = c_OFF_W,
  parameter logic [PC_W-1:0] START_ADDR = '0
) (
  input  npc_sel_t          i_sel,
  input  logic [PC_W-1:0]   i_pc,
  input  logic [PC_W-1:0]   i_target,
  input  logic [OFF_W-1:0]  i_offset,
  output logic [PC_W-1:0]   o_next_pc,
  output logic              o_wrap
);

  logic [PC_W:0]   w_inc;
  logic [PC_W+1:0] w_rel;

  // Two guard bits on the relative sum: nonzero guard means carry-out or borrow.
  assign w_inc = {1'b0, i_pc} + {{PC_W{1'b0}}, 1'b1};
  assign w_rel = {2'b00, i_pc} + {{(PC_W+2-OFF_W){i_offset[OFF_W-1]}}, i_offset};

  always_comb begin
    o_next_pc = i_pc;
    o_wrap    = 1'b0;
    case (i_sel)
      NPC_INC: begin
        o_next_pc = w_inc[PC_W-1:0];
        o_wrap    = w_inc[PC_W];
      end
      NPC_REL: begin
        o_next_pc = w_rel[PC_W-1:0];
        o_wrap    = |w_rel[PC_W+1:PC_W];
      end
      NPC_JUMP: o_next_pc = i_target;
      NPC_LOAD: o_next_pc = START_ADDR;
      default:  o_next_pc = i_pc;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/pc_fetch_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | pc_fetch_ctrl : program counter / fetch FSM (IDLE, RUN, HALTED)             |
// | Optional RUN-cycle counter output enabled by macro PC_CYCLE_COUNT_EN        |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module pc_fetch_ctrl
  import pc_pkg::*;
#(
  parameter int unsigned     PC_W       = c_PC_W,
  parameter int unsigned     OFF_W      = c_OFF_W,
  parameter logic [PC_W-1:0] START_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_stall,
  input  logic              i_halt,
  input  logic              i_jump,
  input  logic [PC_W-1:0]   i_target,
  input  logic              i_branch_rel,
  input  logic [OFF_W-1:0]  i_offset,
  output logic [PC_W-1:0]   o_prog_ctr,
  output logic              o_running,
  output logic              o_done,
  output logic              o_wrapped
`ifdef PC_CYCLE_COUNT_EN
  ,
  output logic [15:0]       o_cycle_ct
`endif
);

  fetch_state_t    r_state;
  logic            r_start_q;
  logic [PC_W-1:0] r_pc;
  logic            r_running;
  logic            r_done;
  logic            r_wrapped;
  npc_sel_t        w_sel;
  logic [PC_W-1:0] w_next_pc;
  logic            w_wrap;

  always_comb begin
    w_sel = NPC_HOLD;
    case (r_state)
      IDLE:    w_sel = NPC_LOAD;
      RUN: begin
        if (i_start)                w_sel = NPC_LOAD;
        else if (i_halt || i_stall) w_sel = NPC_HOLD;
        else if (i_jump)            w_sel = NPC_JUMP;
        else if (i_branch_rel)      w_sel = NPC_REL;
        else                        w_sel = NPC_INC;
      end
      HALTED:  w_sel = i_start ? NPC_LOAD : NPC_HOLD;
      default: w_sel = NPC_LOAD;
    endcase
  end

  pc_next_calc #(
    .PC_W       (PC_W),
    .OFF_W      (OFF_W),
    .START_ADDR (START_ADDR)
  ) u_next_calc (
    .i_sel      (w_sel),
    .i_pc       (r_pc),
    .i_target   (i_target),
    .i_offset   (i_offset),
    .o_next_pc  (w_next_pc),
    .o_wrap     (w_wrap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_start_q <= 1'b0;
      r_pc      <= START_ADDR;
      r_running <= 1'b0;
      r_done    <= 1'b0;
      r_wrapped <= 1'b0;
    end else begin
      r_start_q <= i_start;
      r_pc      <= w_next_pc;
      if (i_start)     r_wrapped <= 1'b0;
      else if (w_wrap) r_wrapped <= 1'b1;
      case (r_state)
        IDLE: begin
          // Leave IDLE only on a sampled high-then-low of start.
          if (r_start_q && !i_start) begin
            r_state   <= RUN;
            r_running <= 1'b1;
          end
        end
        RUN: begin
          if (i_start) begin
            r_state   <= IDLE;
            r_running <= 1'b0;
          end else if (i_halt) begin
            r_state   <= HALTED;
            r_running <= 1'b0;
            r_done    <= 1'b1;
          end
        end
        HALTED: begin
          if (i_start) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_running <= 1'b0;
          r_done    <= 1'b0;
        end
      endcase
    end
  end

  assign o_prog_ctr = r_pc;
  assign o_running  = r_running;
  assign o_done     = r_done;
  assign o_wrapped  = r_wrapped;

`ifdef PC_CYCLE_COUNT_EN
  logic [15:0] r_cycle_ct;

  // Any start sample leads into IDLE, so clearing on start covers IDLE entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    r_cycle_ct <= '0;
    else if (i_start)                              r_cycle_ct <= '0;
    else if (r_state == RUN && r_cycle_ct != '1)   r_cycle_ct <= r_cycle_ct + 16'd1;
  end

  assign o_cycle_ct = r_cycle_ct;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_pc_fetch_ctrl : directed self-checking bench for pc_fetch_ctrl           |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module tb_pc_fetch_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, stall, halt, jump, branch_rel;
  logic [9:0] target;
  logic [7:0] offset;
  logic [9:0] prog_ctr;
  logic       running, done, wrapped;
`ifdef PC_CYCLE_COUNT_EN
  logic [15:0] cycle_ct;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pc_fetch_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (start),
    .i_stall      (stall),
    .i_halt       (halt),
    .i_jump       (jump),
    .i_target     (target),
    .i_branch_rel (branch_rel),
    .i_offset     (offset),
    .o_prog_ctr   (prog_ctr),
    .o_running    (running),
    .o_done       (done),
    .o_wrapped    (wrapped)
`ifdef PC_CYCLE_COUNT_EN
    ,
    .o_cycle_ct   (cycle_ct)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; start = 0; stall = 0; halt = 0; jump = 0; branch_rel = 0;
    target = '0; offset = '0;
    #1;
    check("rst_pc", 32'(prog_ctr), 0);
    check("rst_running", 32'(running), 0);
    check("rst_done", 32'(done), 0);
    check("rst_wrapped", 32'(wrapped), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // start high two edges, then low: RUN follows on the falling-edge sample
    start = 1; tick(); tick();
    start = 0;
    check("idle_running", 32'(running), 0);
    check("idle_pc", 32'(prog_ctr), 0);
    tick();
    check("run_rise", 32'(running), 1);
    check("run_pc0", 32'(prog_ctr), 0);
    tick(); check("run_pc1", 32'(prog_ctr), 1);
    tick(); check("run_pc2", 32'(prog_ctr), 2);
    tick(); check("run_pc3", 32'(prog_ctr), 3);
    tick(); tick(); check("run_pc5", 32'(prog_ctr), 5);

    // jump beats branch
    jump = 1; target = 10'd208; branch_rel = 1; offset = 8'd3;
    tick(); check("jump_prio", 32'(prog_ctr), 208);
    jump = 0; offset = 8'hF8;
    tick(); check("rel_neg8", 32'(prog_ctr), 200);
    check("rel_nowrap", 32'(wrapped), 0);
    branch_rel = 0;

    // top-boundary wrap on increment
    jump = 1; target = 10'd1023;
    tick(); check("jump_1023", 32'(prog_ctr), 1023);
    check("jump_nowrap", 32'(wrapped), 0);
    jump = 0;
    tick(); check("inc_wrap_pc", 32'(prog_ctr), 0);
    check("inc_wrap_flag", 32'(wrapped), 1);
    tick(); check("wrap_sticky", 32'(wrapped), 1);
    check("wrap_pc1", 32'(prog_ctr), 1);

    // single-cycle start pulse mid-RUN: one IDLE cycle, wrapped cleared
    start = 1;
    tick(); check("pulse_pc", 32'(prog_ctr), 0);
    check("pulse_running", 32'(running), 0);
    check("pulse_wrap_clr", 32'(wrapped), 0);
    start = 0;
    tick(); check("resume_running", 32'(running), 1);
    check("resume_pc", 32'(prog_ctr), 0);
    tick(); tick(); check("pre_borrow_pc", 32'(prog_ctr), 2);

    // borrow below zero
    branch_rel = 1; offset = 8'hFB;
    tick(); check("borrow_pc", 32'(prog_ctr), 1021);
    check("borrow_wrap", 32'(wrapped), 1);
    branch_rel = 0;

    // jumps across the boundary never set wrapped
    start = 1; tick(); start = 0; tick();
    jump = 1; target = 10'd1023;
    tick(); check("j2_1023", 32'(prog_ctr), 1023);
    target = 10'd0;
    tick(); check("j2_0", 32'(prog_ctr), 0);
    check("j2_nowrap", 32'(wrapped), 0);

    // stall for three cycles at 40, then halt wins over stall and jump
    target = 10'd40;
    tick(); check("to40", 32'(prog_ctr), 40);
    jump = 0; stall = 1;
    tick(); check("stall1", 32'(prog_ctr), 40);
    tick(); check("stall2", 32'(prog_ctr), 40);
    tick(); check("stall3", 32'(prog_ctr), 40);
    halt = 1; jump = 1; target = 10'd99;
    tick(); check("halt_done", 32'(done), 1);
    check("halt_running", 32'(running), 0);
    check("halt_pc", 32'(prog_ctr), 40);
    halt = 0; stall = 0; branch_rel = 1; offset = 8'd7;
    tick(); check("halted_hold", 32'(prog_ctr), 40);
    check("halted_done", 32'(done), 1);
    jump = 0; branch_rel = 0;
    start = 1;
    tick(); check("halt_exit_done", 32'(done), 0);
    check("halt_exit_pc", 32'(prog_ctr), 0);
    start = 0;
    tick(); check("run_again", 32'(running), 1);

    // ten RUN cycles, two stalled, tenth carries halt
    for (int i = 0; i < 10; i++) begin
      stall = (i == 3 || i == 4);
      halt  = (i == 9);
      tick();
    end
    stall = 0; halt = 0;
    check("cnt_run_pc", 32'(prog_ctr), 7);
    check("cnt_run_done", 32'(done), 1);
`ifdef PC_CYCLE_COUNT_EN
    check("cycle_ct_10", 32'(cycle_ct), 10);
    tick(); tick();
    check("cycle_ct_hold", 32'(cycle_ct), 10);
`endif
    start = 1;
    tick();
`ifdef PC_CYCLE_COUNT_EN
    check("cycle_ct_clr", 32'(cycle_ct), 0);
`endif
    start = 0;
    tick();

    // asynchronous reset mid-RUN at 37
    jump = 1; target = 10'd37;
    tick(); check("to37", 32'(prog_ctr), 37);
    jump = 0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_pc", 32'(prog_ctr), 0);
    check("async_running", 32'(running), 0);
    check("async_done", 32'(done), 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
